// File: rtl/misr_sig_checker.sv
`default_nettype none
// ============================================================================
// Module   : misr_sig_checker
// Purpose  : Runs NUM_SESSIONS MISR compaction sessions back to back. In each
//            session it gates the MISR enable with upstream data validity,
//            waits for the MISR done flag, captures the signature and compares
//            it against that session's golden value. Between sessions it
//            pulses the MISR restart input. A per-session watchdog aborts the
//            run if the MISR never reports done.
// Ports    : clk, rst (sync, active-high)
//            start_i          - begin a run (sampled in IDLE only)
//            data_valid_i     - upstream pattern valid this cycle
//            golden_i         - golden signature of session k at [k*N +: N]
//            sig_i/sig_done_i - MISR signature / MISR done flag
//            misr_en_o        - MISR enable
//            misr_restart_o   - MISR restart (done_in), one cycle per session
//            busy_o, done_o   - run in progress / one-cycle end-of-run pulse
//            pass_o, timeout_o, fail_cnt_o, first_fail_idx_o,
//            first_fail_sig_o - results of the last run
// Revision : 1.0 - initial release
// ============================================================================
module misr_sig_checker #(
    parameter int N            = 32,
    parameter int NUM_SESSIONS = 4,
    parameter int TIMEOUT      = 1024
) (
    input  logic                                                clk,
    input  logic                                                rst,
    input  logic                                                start_i,
    input  logic                                                data_valid_i,
    input  logic [N*NUM_SESSIONS-1:0]                           golden_i,
    input  logic [N-1:0]                                        sig_i,
    input  logic                                                sig_done_i,
    output logic                                                misr_en_o,
    output logic                                                misr_restart_o,
    output logic                                                busy_o,
    output logic                                                done_o,
    output logic                                                pass_o,
    output logic                                                timeout_o,
    output logic [$clog2(NUM_SESSIONS+1)-1:0]                   fail_cnt_o,
    output logic [((NUM_SESSIONS > 1) ? $clog2(NUM_SESSIONS) : 1)-1:0] first_fail_idx_o,
    output logic [N-1:0]                                        first_fail_sig_o
);

    localparam int c_CNT_W = $clog2(NUM_SESSIONS + 1);
    localparam int c_IDX_W = (NUM_SESSIONS > 1) ? $clog2(NUM_SESSIONS) : 1;
    localparam int c_WD_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(NUM_SESSIONS - 1);
    localparam logic [c_WD_W-1:0]  c_WD_LAST  = c_WD_W'(TIMEOUT - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);
    localparam logic [c_IDX_W-1:0] c_IDX_ONE  = c_IDX_W'(1);
    localparam logic [c_WD_W-1:0]  c_WD_ONE   = c_WD_W'(1);

    localparam logic [2:0] c_ST_IDLE    = 3'd0;
    localparam logic [2:0] c_ST_RUN     = 3'd1;
    localparam logic [2:0] c_ST_CHECK   = 3'd2;
    localparam logic [2:0] c_ST_RESTART = 3'd3;
    localparam logic [2:0] c_ST_DONE    = 3'd4;

    logic [2:0]         r_state;
    logic [2:0]         w_state_nxt;
    logic [c_IDX_W-1:0] r_idx;
    logic [c_WD_W-1:0]  r_wdog;
    logic [N-1:0]       r_sig_q;
    logic [c_CNT_W-1:0] r_fail_cnt;
    logic [c_IDX_W-1:0] r_first_idx;
    logic [N-1:0]       r_first_sig;
    logic               r_pass;
    logic               r_timeout;
    logic               r_done;

    logic               w_misr_en;
    logic               w_misr_restart;
    logic               w_busy;
    logic               w_run_end;
    logic               w_mismatch;

    // Golden values unpacked into one word per session.
    logic [N-1:0] w_gold [NUM_SESSIONS];

    generate
        for (genvar gi = 0; gi < NUM_SESSIONS; gi++) begin : g_gold
            assign w_gold[gi] = golden_i[gi*N +: N];
        end
    endgenerate

    assign w_mismatch = (r_sig_q != w_gold[r_idx]);
    // A watchdog abort ends the whole run, not just the current session.
    assign w_run_end  = r_timeout | (r_idx == c_LAST_IDX);

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM next state and MISR-facing outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt    = r_state;
        w_misr_en      = 1'b0;
        w_misr_restart = 1'b0;
        w_busy         = 1'b1;
        case (r_state)
            c_ST_IDLE: begin
                w_busy = 1'b0;
                if (start_i) begin
                    w_state_nxt = c_ST_RUN;
                end
            end
            c_ST_RUN: begin
                // Stop clocking the MISR once it reports done so the
                // signature it presents stays the one we capture.
                w_misr_en = data_valid_i & ~sig_done_i;
                if (sig_done_i) begin
                    w_state_nxt = c_ST_CHECK;
                end else if (r_wdog == c_WD_LAST) begin
                    w_state_nxt = c_ST_RESTART;
                end
            end
            c_ST_CHECK: begin
                w_state_nxt = c_ST_RESTART;
            end
            c_ST_RESTART: begin
                // The MISR only samples its restart input while enabled.
                w_misr_en      = 1'b1;
                w_misr_restart = 1'b1;
                w_state_nxt    = w_run_end ? c_ST_DONE : c_ST_RUN;
            end
            c_ST_DONE: begin
                w_state_nxt = c_ST_IDLE;
            end
            default: begin
                w_busy      = 1'b0;
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: session index, watchdog, capture and result registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx       <= '0;
            r_wdog      <= '0;
            r_sig_q     <= '0;
            r_fail_cnt  <= '0;
            r_first_idx <= '0;
            r_first_sig <= '0;
            r_pass      <= 1'b0;
            r_timeout   <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (start_i) begin
                        r_idx       <= '0;
                        r_wdog      <= '0;
                        r_fail_cnt  <= '0;
                        r_first_idx <= '0;
                        r_first_sig <= '0;
                        r_pass      <= 1'b0;
                        r_timeout   <= 1'b0;
                    end
                end
                c_ST_RUN: begin
                    r_wdog <= r_wdog + c_WD_ONE;
                    if (sig_done_i) begin
                        r_sig_q <= sig_i;
                    end else if (r_wdog == c_WD_LAST) begin
                        r_timeout <= 1'b1;
                    end
                end
                c_ST_CHECK: begin
                    if (w_mismatch) begin
                        r_fail_cnt <= r_fail_cnt + c_CNT_ONE;
                        if (r_fail_cnt == '0) begin
                            r_first_idx <= r_idx;
                            r_first_sig <= r_sig_q;
                        end
                    end
                end
                c_ST_RESTART: begin
                    r_wdog <= '0;
                    if (w_run_end) begin
                        // fail count is final here: CHECK has already run.
                        r_done <= 1'b1;
                        r_pass <= (r_fail_cnt == '0) & ~r_timeout;
                    end else begin
                        r_idx <= r_idx + c_IDX_ONE;
                    end
                end
                c_ST_DONE: begin
                    r_done <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

    assign misr_en_o        = w_misr_en;
    assign misr_restart_o   = w_misr_restart;
    assign busy_o           = w_busy;
    assign done_o           = r_done;
    assign pass_o           = r_pass;
    assign timeout_o        = r_timeout;
    assign fail_cnt_o       = r_fail_cnt;
    assign first_fail_idx_o = r_first_idx;
    assign first_fail_sig_o = r_first_sig;

endmodule
`default_nettype wire

// File: tb/tb_misr_sig_checker.sv
`default_nettype none
// ============================================================================
// Module   : tb_misr_sig_checker
// Purpose  : Scoreboard bench for misr_sig_checker. A driver plays a simple
//            MISR (done after a chosen number of cycles, signature held until
//            restart) and random data_valid; a monitor compares the MISR
//            handshake every cycle and the run results on each done pulse.
// Revision : 1.0 - initial release
// ============================================================================
module tb_misr_sig_checker;

    localparam int N            = 8;
    localparam int NUM_SESSIONS = 2;
    localparam int TIMEOUT      = 16;
    localparam logic [15:0] GOLD = 16'h3CA5;   // s0 = 0xA5, s1 = 0x3C

    logic        clk;
    logic        rst;
    logic        start_i;
    logic        data_valid_i;
    logic [15:0] golden_i;
    logic [7:0]  sig_i;
    logic        sig_done_i;
    logic        misr_en_o;
    logic        misr_restart_o;
    logic        busy_o;
    logic        done_o;
    logic        pass_o;
    logic        timeout_o;
    logic [1:0]  fail_cnt_o;
    logic [0:0]  first_fail_idx_o;
    logic [7:0]  first_fail_sig_o;

    misr_sig_checker #(
        .N            (N),
        .NUM_SESSIONS (NUM_SESSIONS),
        .TIMEOUT      (TIMEOUT)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .start_i          (start_i),
        .data_valid_i     (data_valid_i),
        .golden_i         (golden_i),
        .sig_i            (sig_i),
        .sig_done_i       (sig_done_i),
        .misr_en_o        (misr_en_o),
        .misr_restart_o   (misr_restart_o),
        .busy_o           (busy_o),
        .done_o           (done_o),
        .pass_o           (pass_o),
        .timeout_o        (timeout_o),
        .fail_cnt_o       (fail_cnt_o),
        .first_fail_idx_o (first_fail_idx_o),
        .first_fail_sig_o (first_fail_sig_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       pass;
        logic       to;
        int         fails;
        int         fidx;
        logic [7:0] fsig;
    } res_t;

    res_t sb_q[$];
    res_t last_res;
    res_t zero_res;
    res_t mon_r;

    int   checks   = 0;
    int   failures = 0;

    logic mon_on   = 1'b0;
    logic chk_zero = 1'b0;
    logic chk_hold = 1'b0;
    logic exp_en, exp_rs, exp_busy, exp_done;

    function automatic logic [7:0] gold_of(input int k);
        logic [15:0] g;
        g = GOLD;
        return g[k*8 +: 8];
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic cmp_res(input string tag, input res_t r);
        chk({tag, "_pass"},       32'(pass_o),           32'(r.pass));
        chk({tag, "_timeout"},    32'(timeout_o),        32'(r.to));
        chk({tag, "_fail_cnt"},   32'(fail_cnt_o),       32'(r.fails));
        chk({tag, "_first_idx"},  32'(first_fail_idx_o), 32'(r.fidx));
        chk({tag, "_first_sig"},  32'(first_fail_sig_o), 32'(r.fsig));
    endtask

    // Monitor: per-cycle handshake and scoreboard pop on done_o.
    always @(negedge clk) begin
        if (mon_on) begin
            chk("misr_en",      32'(misr_en_o),      32'(exp_en));
            chk("misr_restart", 32'(misr_restart_o), 32'(exp_rs));
            chk("busy",         32'(busy_o),         32'(exp_busy));
            chk("done",         32'(done_o),         32'(exp_done));
            if (done_o === 1'b1) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL done_unexpected: got done_o=1 expected no pending run at %0t", $time);
                end else begin
                    mon_r    = sb_q.pop_front();
                    last_res = mon_r;
                    cmp_res("run", mon_r);
                end
            end
            if (chk_zero) cmp_res("reset", zero_res);
            if (chk_hold) cmp_res("hold", last_res);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_exp(input logic en, input logic rs, input logic bz, input logic dn);
        exp_en   = en;
        exp_rs   = rs;
        exp_busy = bz;
        exp_done = dn;
    endtask

    // One run: lat[k] = RUN cycles before the MISR reports done in session k,
    // sv[k] = signature it reports. rst_sess >= 0 pulses rst in that session.
    task automatic run(input int l0, input int l1, input logic [7:0] s0, input logic [7:0] s1,
                       input int rst_sess, input int rst_j);
        int         lat [2];
        logic [7:0] sv  [2];
        res_t       r;
        bit         timed;
        bit         fin;
        int         j;
        lat[0] = l0; lat[1] = l1;
        sv[0]  = s0; sv[1]  = s1;

        // Reference result from the session plan.
        r.pass = 1'b0; r.to = 1'b0; r.fails = 0; r.fidx = 0; r.fsig = 8'h00;
        for (int k = 0; k < NUM_SESSIONS; k++) begin
            if (lat[k] >= TIMEOUT) begin
                r.to = 1'b1;
                break;
            end
            if (sv[k] != gold_of(k)) begin
                if (r.fails == 0) begin
                    r.fidx = k;
                    r.fsig = sv[k];
                end
                r.fails++;
            end
        end
        r.pass = (r.fails == 0) && !r.to;
        if (rst_sess < 0) sb_q.push_back(r);

        cyc();
        start_i      = 1'b1;
        data_valid_i = 1'($urandom_range(0, 1));
        set_exp(1'b0, 1'b0, 1'b0, 1'b0);
        timed = 1'b0;
        for (int k = 0; k < NUM_SESSIONS && !timed; k++) begin
            j   = 0;
            fin = 1'b0;
            while (!fin) begin
                cyc();
                start_i      = 1'b0;
                data_valid_i = 1'($urandom_range(0, 1));
                sig_done_i   = (j >= lat[k]);
                sig_i        = sig_done_i ? sv[k] : 8'($urandom);
                set_exp(data_valid_i & ~sig_done_i, 1'b0, 1'b1, 1'b0);
                if (k == rst_sess && j == rst_j) begin
                    rst = 1'b1;
                    cyc();
                    rst        = 1'b0;
                    sig_done_i = 1'b0;
                    set_exp(1'b0, 1'b0, 1'b0, 1'b0);
                    chk_zero = 1'b1;
                    cyc();
                    chk_zero = 1'b0;
                    return;
                end
                if (sig_done_i) begin
                    // Compare cycle: the signature must already be captured.
                    cyc();
                    sig_i        = 8'($urandom);
                    data_valid_i = 1'($urandom_range(0, 1));
                    set_exp(1'b0, 1'b0, 1'b1, 1'b0);
                    fin = 1'b1;
                end else if (j == TIMEOUT - 1) begin
                    timed = 1'b1;
                    fin   = 1'b1;
                end else begin
                    j++;
                end
            end
            cyc();
            data_valid_i = 1'($urandom_range(0, 1));
            set_exp(1'b1, 1'b1, 1'b1, 1'b0);
        end
        cyc();
        sig_done_i   = 1'b0;
        data_valid_i = 1'($urandom_range(0, 1));
        set_exp(1'b0, 1'b0, 1'b1, 1'b1);
        start_i = 1'($urandom_range(0, 1));    // must be ignored in DONE
        cyc();
        start_i = 1'b0;
        set_exp(1'b0, 1'b0, 1'b0, 1'b0);
        chk_hold = 1'b1;
        cyc();
        chk_hold = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int         la, lb, sel;
        logic [7:0] sa, sb;
        zero_res.pass = 1'b0; zero_res.to = 1'b0; zero_res.fails = 0;
        zero_res.fidx = 0;    zero_res.fsig = 8'h00;
        last_res = zero_res;
        rst = 1'b1; start_i = 1'b0; data_valid_i = 1'b0;
        golden_i = GOLD; sig_i = 8'h00; sig_done_i = 1'b0;
        set_exp(1'b0, 1'b0, 1'b0, 1'b0);
        cyc();
        mon_on   = 1'b1;
        chk_zero = 1'b1;
        cyc();
        rst = 1'b0;
        cyc();
        chk_zero = 1'b0;

        run(3,   2,  8'hA5, 8'h3C, -1, 0);   // all pass
        run(1,   4,  8'hA5, 8'h3D, -1, 0);   // s1 mismatch
        run(0,   2,  8'h00, 8'hFF, -1, 0);   // both mismatch
        run(100, 3,  8'hA5, 8'h3C, -1, 0);   // watchdog in s0
        run(15,  15, 8'hA5, 8'h3C, -1, 0);   // done on last watchdog cycle
        run(2,   30, 8'h00, 8'h3C, 1,  3);   // reset during s1
        run(2,   1,  8'hA5, 8'h3C, -1, 0);   // clean run after reset

        for (int i = 0; i < 20; i++) begin
            sel = $urandom_range(0, 9);
            la  = (sel == 0) ? TIMEOUT - 1 : (sel == 1) ? TIMEOUT + $urandom_range(0, 3) : $urandom_range(0, 5);
            sel = $urandom_range(0, 9);
            lb  = (sel == 0) ? TIMEOUT - 1 : (sel == 1) ? TIMEOUT + $urandom_range(0, 3) : $urandom_range(0, 5);
            sa  = $urandom_range(0, 1) ? gold_of(0) : 8'($urandom);
            sb  = $urandom_range(0, 1) ? gold_of(1) : 8'($urandom);
            run(la, lb, sa, sb, -1, 0);
        end

        cyc();
        cyc();
        chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
